// File: rtl/dp_exec_pkg.sv
// Shared encodings for the datapath execution unit: ALU ops, FSM states, status bit positions.
// Status word layout is {V,C,N,Z}.
package dp_exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_SHL   = 3'd5,
        OP_SHR   = 3'd6,
        OP_PASSB = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_C = 2;
    localparam int STAT_V = 3;

endpackage

// File: rtl/dp_exec_alu.sv
// Combinational ALU: A, B, carry-in and op to result, carry-out and {V,C,N,Z} status.
// Zero latency; no flow control.
module dp_exec_alu
    import dp_exec_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic [3:0]        status
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W:0]   sum;
    logic [SH_W-1:0]   shamt;
    logic              ovf;

    assign shamt = b[SH_W-1:0];

    always_comb begin
        sum    = '0;
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
                result = sum[DATA_W-1:0];
                cout   = sum[DATA_W];
                ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                // a + ~b + cin == a - b - !cin; carry-out high means no borrow
                sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, cin};
                result = sum[DATA_W-1:0];
                cout   = sum[DATA_W];
                ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << shamt;
            OP_SHR:  result = a >> shamt;
            default: result = b;
        endcase
        status         = '0;
        status[STAT_V] = ovf;
        status[STAT_C] = cout;
        status[STAT_N] = result[DATA_W-1];
        status[STAT_Z] = (result == '0);
    end

endmodule

// File: rtl/datapath_exec_unit.sv
// Register file + ALU + RAM execution unit, one command in flight; DATAPATH_EXEC_IMM_EN enables the immediate A operand.
// Command to rsp_valid in 4 cycles; cmd_ready stays low and the response holds until rsp_ready.
module datapath_exec_unit
    import dp_exec_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int REG_N     = 32,
    parameter int RAM_DEPTH = 256,
    localparam int RA_W     = $clog2(REG_N),
    localparam int MA_W     = $clog2(RAM_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [RA_W-1:0]   cmd_ra,
    input  logic [RA_W-1:0]   cmd_rb,
    input  logic [RA_W-1:0]   cmd_rd,
    input  logic              cmd_cin,
    input  logic              cmd_wb,
    input  logic              cmd_load,
    input  logic              cmd_store,
    input  logic              cmd_imm_sel,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              ext_we,
    input  logic [RA_W-1:0]   ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_status,
    output logic              rsp_cout
);

    state_t            state, nxt;
    alu_op_t           op_q;
    logic [RA_W-1:0]   ra_q, rb_q, rd_q;
    logic              cin_q, wb_q, load_q, store_q;
    logic [DATA_W-1:0] a_q, b_q, a_sel, res_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cout;
    logic [3:0]        alu_status;
    logic [MA_W-1:0]   mem_addr;
    logic              wb_fire;

    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] ram  [RAM_DEPTH];

`ifdef DATAPATH_EXEC_IMM_EN
    logic              imm_sel_q;
    logic [DATA_W-1:0] imm_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
        end else if (state == S_IDLE && cmd_valid) begin
            imm_sel_q <= cmd_imm_sel;
            imm_q     <= cmd_imm;
        end
    end

    assign a_sel = imm_sel_q ? imm_q : regs[ra_q];
`else
    logic imm_unused;
    assign imm_unused = ^{cmd_imm_sel, cmd_imm};
    assign a_sel      = regs[ra_q];
`endif

    always_comb begin
        nxt       = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) nxt = S_READ;
            end
            S_READ: nxt = S_EXEC;
            S_EXEC: nxt = S_MEM;
            S_MEM:  nxt = S_DONE;
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    dp_exec_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .cin    (cin_q),
        .op     (op_q),
        .result (alu_res),
        .cout   (alu_cout),
        .status (alu_status)
    );

    assign mem_addr = res_q[MA_W-1:0];
    assign wb_fire  = (state == S_DONE) && rsp_ready && wb_q && (rd_q != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= OP_ADD;
            ra_q       <= '0;
            rb_q       <= '0;
            rd_q       <= '0;
            cin_q      <= 1'b0;
            wb_q       <= 1'b0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            rsp_result <= '0;
            rsp_status <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && cmd_valid) begin
                op_q    <= alu_op_t'(cmd_op);
                ra_q    <= cmd_ra;
                rb_q    <= cmd_rb;
                rd_q    <= cmd_rd;
                cin_q   <= cmd_cin;
                wb_q    <= cmd_wb;
                load_q  <= cmd_load;
                store_q <= cmd_store;
            end
            if (state == S_READ) begin
                a_q <= a_sel;
                b_q <= regs[rb_q];
            end
            if (state == S_EXEC) begin
                res_q      <= alu_res;
                rsp_cout   <= alu_cout;
                rsp_status <= alu_status;
            end
            // Nonblocking read returns the pre-store word when load and store coincide
            if (state == S_MEM) rsp_result <= load_q ? ram[mem_addr] : res_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state == S_MEM && store_q) ram[mem_addr] <= b_q;
    end

    // Writeback is ordered after the external write so it wins on an address collision
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            if (ext_we && ext_addr != '0) regs[ext_addr] <= ext_data;
            if (wb_fire) regs[rd_q] <= rsp_result;
        end
    end

endmodule

// File: tb/tb_datapath_exec_unit.sv
// Directed bench for datapath_exec_unit: expected responses queued at issue, popped at the response handshake.
module tb_datapath_exec_unit;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, PASSB = 3'd7;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  ra, rb, rd;
        logic        cin, wb, load, store, imm_sel;
        logic [63:0] imm;
    } cmd_s;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic [3:0]  st;
        logic        cout;
    } exp_s;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_ra, cmd_rb, cmd_rd;
    logic        cmd_cin, cmd_wb, cmd_load, cmd_store, cmd_imm_sel;
    logic [63:0] cmd_imm;
    logic        ext_we;
    logic [4:0]  ext_addr;
    logic [63:0] ext_data;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_status;
    logic        rsp_cout;

    int   errors = 0;
    int   checks = 0;
    exp_s exp_q[$];

    always #5 clock = ~clock;

    datapath_exec_unit dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_rd      (cmd_rd),
        .cmd_cin     (cmd_cin),
        .cmd_wb      (cmd_wb),
        .cmd_load    (cmd_load),
        .cmd_store   (cmd_store),
        .cmd_imm_sel (cmd_imm_sel),
        .cmd_imm     (cmd_imm),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_data    (ext_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_status  (rsp_status),
        .rsp_cout    (rsp_cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic cmd_s mk(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                                input logic [4:0] rd, input logic wb = 1'b0, input logic cin = 1'b0,
                                input logic load = 1'b0, input logic store = 1'b0);
        cmd_s c;
        c.op = op; c.ra = ra; c.rb = rb; c.rd = rd;
        c.wb = wb; c.cin = cin; c.load = load; c.store = store;
        c.imm_sel = 1'b0; c.imm = '0;
        return c;
    endfunction

    function automatic exp_s ex(input string tag, input logic [63:0] res, input logic [3:0] st,
                                input logic cout);
        exp_s e;
        e.tag = tag; e.res = res; e.st = st; e.cout = cout;
        return e;
    endfunction

    task automatic drive_cmd(input cmd_s c);
        cmd_op = c.op; cmd_ra = c.ra; cmd_rb = c.rb; cmd_rd = c.rd;
        cmd_cin = c.cin; cmd_wb = c.wb; cmd_load = c.load; cmd_store = c.store;
        cmd_imm_sel = c.imm_sel; cmd_imm = c.imm;
    endtask

    task automatic ext_write(input logic [4:0] a, input logic [63:0] d);
        ext_we = 1'b1; ext_addr = a; ext_data = d;
        @(posedge clock); @(negedge clock);
        ext_we = 1'b0;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first DONE cycle (or timeout)
    task automatic issue(input cmd_s c, input exp_s e);
        int cyc;
        check({e.tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        drive_cmd(c);
        cmd_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clock); @(negedge clock);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check({e.tag, "_latency"}, 64'(cyc), 64'd4);
    endtask

    task automatic complete(input bit ext_do = 1'b0, input logic [4:0] ea = '0, input logic [63:0] ed = '0);
        exp_s e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed=response expected=none");
            return;
        end
        e = exp_q.pop_front();
        check({e.tag, "_valid"},  64'(rsp_valid),  64'd1);
        check({e.tag, "_result"}, rsp_result,      e.res);
        check({e.tag, "_status"}, 64'(rsp_status), 64'(e.st));
        check({e.tag, "_cout"},   64'(rsp_cout),   64'(e.cout));
        rsp_ready = 1'b1;
        if (ext_do) begin
            ext_we = 1'b1; ext_addr = ea; ext_data = ed;
        end
        @(posedge clock); @(negedge clock);
        rsp_ready = 1'b0;
        ext_we = 1'b0;
        check({e.tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_s c;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; ext_we = 1'b0;
        ext_addr = '0; ext_data = '0;
        drive_cmd(mk(ADD, 0, 0, 0));
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_cmd_ready",  64'(cmd_ready),  64'd1);
        check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
        check("rst_rsp_result", rsp_result,      64'd0);
        check("rst_rsp_status", 64'(rsp_status), 64'd0);
        check("rst_rsp_cout",   64'(rsp_cout),   64'd0);
        reset = 1'b0;

        ext_write(1, 64'd5);
        ext_write(2, 64'd7);
        ext_write(6, 64'd5);
        ext_write(7, 64'h7FFF_FFFF_FFFF_FFFF);
        ext_write(8, 64'd1);

        issue(mk(ADD, 1, 2, 3, 1), ex("add", 64'd12, 4'b0000, 1'b0));       complete();
        issue(mk(PASSB, 0, 3, 0), ex("read_r3", 64'd12, 4'b0000, 1'b0));     complete();
        issue(mk(SUB, 1, 6, 0, 0, 1), ex("sub_zero", 64'd0, 4'b0101, 1'b1));  complete();
        issue(mk(SUB, 1, 2, 0, 0, 0), ex("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFD, 4'b0010, 1'b0)); complete();
        issue(mk(ADD, 7, 8, 0), ex("add_ovf", 64'h8000_0000_0000_0000, 4'b1010, 1'b0)); complete();
        issue(mk(AND_, 1, 2, 0, 0, 1), ex("and_cin", 64'd5, 4'b0000, 1'b0));  complete();
        issue(mk(OR_, 1, 2, 0), ex("or", 64'd7, 4'b0000, 1'b0));              complete();
        issue(mk(XOR_, 1, 2, 0), ex("xor", 64'd2, 4'b0000, 1'b0));            complete();
        issue(mk(SHL, 1, 2, 0), ex("shl", 64'h280, 4'b0000, 1'b0));           complete();
        issue(mk(SHR, 7, 2, 0), ex("shr", 64'h00FF_FFFF_FFFF_FFFF, 4'b0000, 1'b0)); complete();

        ext_write(9, 64'hBB);
        ext_write(10, 64'hAB);
        ext_write(11, 64'h10);
        issue(mk(XOR_, 9, 10, 0, 0, 0, 0, 1), ex("store", 64'h10, 4'b0000, 1'b0));   complete();
        issue(mk(PASSB, 0, 11, 4, 1, 0, 1, 0), ex("load", 64'hAB, 4'b0000, 1'b0));   complete();
        issue(mk(PASSB, 0, 4, 0), ex("read_r4", 64'hAB, 4'b0000, 1'b0));             complete();
        issue(mk(PASSB, 0, 11, 0, 0, 0, 1, 1), ex("ldst_old", 64'hAB, 4'b0000, 1'b0)); complete();
        issue(mk(PASSB, 0, 11, 0, 0, 0, 1, 0), ex("ldst_new", 64'h10, 4'b0000, 1'b0)); complete();

        issue(mk(ADD, 1, 2, 12, 1), ex("stall", 64'd12, 4'b0000, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_valid",     64'(rsp_valid), 64'd1);
            check("stall_result",    rsp_result,     64'd12);
            check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
            check("stall_no_wb",     dut.regs[12],   64'd0);
        end
        complete();
        issue(mk(PASSB, 0, 12, 0), ex("read_r12", 64'd12, 4'b0000, 1'b0));   complete();

        issue(mk(ADD, 1, 2, 3, 1), ex("collide", 64'd12, 4'b0000, 1'b0));    complete(1'b1, 5'd3, 64'd9);
        issue(mk(PASSB, 0, 3, 0), ex("read_r3_win", 64'd12, 4'b0000, 1'b0)); complete();
        ext_write(3, 64'd9);
        issue(mk(PASSB, 0, 3, 0), ex("read_r3_ext", 64'd9, 4'b0000, 1'b0));  complete();

        issue(mk(ADD, 1, 2, 0, 1), ex("wb_r0", 64'd12, 4'b0000, 1'b0));      complete();
        issue(mk(PASSB, 0, 0, 0), ex("read_r0", 64'd0, 4'b0001, 1'b0));      complete();
        ext_write(0, 64'h55);
        issue(mk(PASSB, 0, 0, 0), ex("read_r0_ext", 64'd0, 4'b0001, 1'b0));  complete();

        c = mk(ADD, 1, 2, 0);
        c.imm_sel = 1'b1;
        c.imm = 64'd100;
`ifdef DATAPATH_EXEC_IMM_EN
        issue(c, ex("imm", 64'd107, 4'b0000, 1'b0));
`else
        issue(c, ex("imm_ignored", 64'd12, 4'b0000, 1'b0));
`endif
        complete();

        // Store of 0x55 to address 0x10 abandoned by a reset during EXEC
        ext_write(13, 64'h45);
        ext_write(14, 64'h55);
        drive_cmd(mk(XOR_, 13, 14, 15, 1, 0, 0, 1));
        cmd_valid = 1'b1;
        @(posedge clock); @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstx_rsp_valid",  64'(rsp_valid), 64'd1 - 64'd1);
        check("rstx_cmd_ready",  64'(cmd_ready), 64'd1);
        check("rstx_rsp_result", rsp_result,     64'd0);
        check("rstx_r13_clear",  dut.regs[13],   64'd0);
        issue(mk(PASSB, 0, 15, 0), ex("rstx_r15", 64'd0, 4'b0001, 1'b0));    complete();
        ext_write(11, 64'h10);
        issue(mk(PASSB, 0, 11, 0, 0, 0, 1, 0), ex("rstx_ram_kept", 64'h10, 4'b0000, 1'b0)); complete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
